// File: rtl/spi_master_ctrl.sv
// Register-access SPI master (mode 0, MSB first) for converter control ports.
// One command per valid/ready handshake; returns read data or a write completion pulse.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a command, ss high
// SETUP | ss low, first frame bit on mosi before the first sck rise
// HIGH  | sck high half-period; miso sampled as sck rises
// LOW   | sck low half-period; next bit on mosi, or ss hold after last bit
// GAP   | ss high guard time between frames
// DONE  | rsp_valid pulse, then back to IDLE
module spi_master_ctrl #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int SCK_DIV   = 2,
  parameter int SS_GAP    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_read,
  input  logic [ADDR_BITS-2:0] cmd_addr,
  input  logic [DATA_BITS-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 sck,
  output logic                 ss,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int FRAME_BITS = ADDR_BITS + DATA_BITS;
  localparam int CNT_MAX    = (SCK_DIV > SS_GAP) ? SCK_DIV : SS_GAP;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(SCK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(SS_GAP - 1);
  localparam logic [BIT_W-1:0] BITS_LOAD = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_GAP,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bits_q, bits_d;
  logic [FRAME_BITS-1:0] frame_q;
  logic [DATA_BITS-1:0]  rx_q;
  logic [DATA_BITS:0]    rx_shift;
  logic                  read_q;
  logic                  accept;
  logic                  shift_tx;
  logic                  sample_rx;
  logic                  ss_d;
  logic                  sck_d;
  logic                  mosi_d;
  logic                  rsp_d;

  assign accept   = (state_q == S_IDLE) && cmd_ready && cmd_valid;
  assign rx_shift = {rx_q, miso};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bits_d    = bits_q;
    ss_d      = 1'b1;
    sck_d     = 1'b0;
    mosi_d    = 1'b0;
    shift_tx  = 1'b0;
    sample_rx = 1'b0;
    rsp_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = DIV_LOAD;
          bits_d  = BITS_LOAD;
        end
      end
      S_SETUP: begin
        ss_d   = 1'b0;
        mosi_d = frame_q[FRAME_BITS-1];
        if (cnt_q == '0) begin
          state_d = S_HIGH;
          cnt_d   = DIV_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HIGH: begin
        ss_d      = 1'b0;
        sck_d     = 1'b1;
        mosi_d    = frame_q[FRAME_BITS-1];
        sample_rx = (cnt_q == DIV_LOAD);
        if (cnt_q == '0) begin
          state_d  = S_LOW;
          cnt_d    = DIV_LOAD;
          // Shift one cycle early so the new bit lands on mosi with the sck fall;
          // after the last bit the frame is held so mosi stays put through ss hold.
          shift_tx = (bits_q != '0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_LOW: begin
        ss_d   = 1'b0;
        mosi_d = frame_q[FRAME_BITS-1];
        if (cnt_q == '0) begin
          if (bits_q == '0) begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = S_HIGH;
            cnt_d   = DIV_LOAD;
            bits_d  = bits_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        rsp_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q <= '0;
      read_q  <= 1'b0;
      rx_q    <= '0;
    end else begin
      if (accept) begin
        frame_q <= {cmd_read, cmd_addr, (cmd_read ? {DATA_BITS{1'b0}} : cmd_wdata)};
        read_q  <= cmd_read;
      end else if (shift_tx) begin
        frame_q <= {frame_q[FRAME_BITS-2:0], 1'b0};
      end
      // Address-phase samples fall off the top; only the data-phase bits survive.
      if (sample_rx) begin
        rx_q <= rx_shift[DATA_BITS-1:0];
      end
    end
  end

  // Pin and handshake registers trail the state register by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss        <= 1'b1;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      ss        <= ss_d;
      sck       <= sck_d;
      mosi      <= mosi_d;
      cmd_ready <= (state_q == S_IDLE) && !accept;
      busy      <= accept || (state_q != S_IDLE);
      rsp_valid <= rsp_d;
      if (rsp_d) begin
        rsp_rdata <= read_q ? rx_q : '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: slave device model on the pins plus a
// register-level reference model; random commands, timing and abort scenarios.
module tb_spi_master_ctrl;

  localparam int DIV  = 2;
  localparam int GAP  = 4;
  localparam int FB   = 16;
  localparam int LAT  = 1 + DIV * (2 * FB + 1) + GAP;
  localparam int SSLO = DIV * (2 * FB + 1);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_read = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       sck;
  logic       ss;
  logic       mosi;
  logic       miso = 1'bz;

  logic       aux_valid = 1'b0;
  logic [1:0] aux_ready, aux_rsp, aux_busy, aux_sck, aux_ss, aux_mosi;
  logic [7:0] aux_rdata0, aux_rdata1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(.ADDR_BITS(8), .DATA_BITS(8), .SCK_DIV(DIV), .SS_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_read(cmd_read), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  spi_master_ctrl #(.ADDR_BITS(8), .DATA_BITS(8), .SCK_DIV(1), .SS_GAP(GAP)) u_div1 (
    .clk(clk), .reset(reset), .cmd_valid(aux_valid), .cmd_ready(aux_ready[0]),
    .cmd_read(1'b0), .cmd_addr(7'h55), .cmd_wdata(8'h3c),
    .rsp_valid(aux_rsp[0]), .rsp_rdata(aux_rdata0), .busy(aux_busy[0]),
    .sck(aux_sck[0]), .ss(aux_ss[0]), .mosi(aux_mosi[0]), .miso(1'b0)
  );

  spi_master_ctrl #(.ADDR_BITS(8), .DATA_BITS(8), .SCK_DIV(3), .SS_GAP(GAP)) u_div3 (
    .clk(clk), .reset(reset), .cmd_valid(aux_valid), .cmd_ready(aux_ready[1]),
    .cmd_read(1'b0), .cmd_addr(7'h55), .cmd_wdata(8'h3c),
    .rsp_valid(aux_rsp[1]), .rsp_rdata(aux_rdata1), .busy(aux_busy[1]),
    .sck(aux_sck[1]), .ss(aux_ss[1]), .mosi(aux_mosi[1]), .miso(1'b0)
  );

  // Slave device: 7-bit address, 8-bit registers, mode 0.
  logic [7:0]  s_mem [128];
  logic [15:0] s_sh = '0;
  int          s_cnt = 0;
  logic        s_read = 1'b0;
  logic [6:0]  s_addr = '0;
  logic [7:0]  s_tmp;
  logic [15:0] frames_q [$];

  always @(negedge ss) begin
    s_cnt = 0;
    s_sh  = '0;
  end

  always @(posedge sck) begin
    if (ss === 1'b0) begin
      s_sh = {s_sh[14:0], mosi};
      s_cnt++;
      if (s_cnt == 8) begin
        s_read = s_sh[7];
        s_addr = s_sh[6:0];
      end
    end
  end

  always @(negedge sck) begin
    if (ss === 1'b0 && s_read && s_cnt >= 8 && s_cnt < 16) begin
      s_tmp = s_mem[s_addr];
      miso  = s_tmp[15-s_cnt];
    end else begin
      miso = 1'bz;
    end
  end

  always @(posedge ss) begin
    if (s_cnt == 16) begin
      frames_q.push_back(s_sh);
      if (!s_read) s_mem[s_addr] = s_sh[7:0];
    end
    s_cnt = 0;
    miso  = 1'bz;
  end

  // Reference register map, updated from command semantics only.
  logic [7:0] ref_mem [128];

  task automatic do_cmd(input logic rd, input logic [6:0] a, input logic [7:0] d,
                        input bit toggle, input string name);
    logic [15:0] exp_frame;
    logic [7:0]  exp_rdata;
    logic [15:0] got;
    logic        prev_sck;
    int          w, lat, sslow, rises;
    exp_frame = {rd, a, (rd ? 8'h00 : d)};
    exp_rdata = rd ? ref_mem[a] : 8'h00;
    if (!rd) ref_mem[a] = d;
    cmd_read = rd; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL %s accept: cmd_ready=%b after %0d cycles, required 1", name, cmd_ready, w);
      errors++;
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    lat = -1; sslow = 0; rises = 0; prev_sck = 1'b0;
    for (int off = 0; off < 200; off++) begin
      @(negedge clk);
      if (off == 0) begin
        cmd_valid = 1'b0;
        checks++;
        if ({busy, cmd_ready} !== 2'b10) begin
          $display("FAIL %s accept_flags: busy,cmd_ready=%b required 10", name, {busy, cmd_ready});
          errors++;
        end
      end
      if (toggle) begin
        cmd_addr = 7'($urandom); cmd_wdata = 8'($urandom); cmd_read = 1'($urandom);
      end
      if (ss === 1'b0) sslow++;
      if (sck === 1'b1 && prev_sck !== 1'b1) rises++;
      prev_sck = sck;
      if (rsp_valid === 1'b1) begin
        lat = off;
        break;
      end
    end
    checks++;
    if (lat != LAT) begin
      $display("FAIL %s latency: got %0d required %0d", name, lat, LAT); errors++;
    end
    checks++;
    if (rsp_rdata !== exp_rdata || busy !== 1'b1) begin
      $display("FAIL %s rsp: rdata=%h busy=%b required rdata=%h busy=1", name, rsp_rdata, busy, exp_rdata);
      errors++;
    end
    checks++;
    if (sslow != SSLO || rises != FB) begin
      $display("FAIL %s framing: ss_low=%0d sck_rises=%0d required %0d %0d", name, sslow, rises, SSLO, FB);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== exp_rdata || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL %s post: valid=%b rdata=%h ready=%b busy=%b required 0 %h 1 0",
               name, rsp_valid, rsp_rdata, cmd_ready, busy, exp_rdata);
      errors++;
    end
    checks++;
    if (frames_q.size() == 0) begin
      $display("FAIL %s frame: no frame seen, required %h", name, exp_frame); errors++;
    end else begin
      got = frames_q.pop_front();
      if (got !== exp_frame) begin
        $display("FAIL %s frame: got %h required %h", name, got, exp_frame); errors++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ss, sck, mosi, cmd_ready, rsp_valid, busy} !== 6'b100000 || rsp_rdata !== 8'h00) begin
      $display("FAIL reset_state: ss,sck,mosi,ready,valid,busy=%b rdata=%h required 100000 00",
               {ss, sck, mosi, cmd_ready, rsp_valid, busy}, rsp_rdata);
      errors++;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_release: ready=%b busy=%b required 1 0", cmd_ready, busy); errors++;
    end
  endtask

  task automatic test_write();
    do_cmd(1'b0, 7'h10, 8'h12, 1'b0, "write_0x10");
    checks++;
    if (s_mem[7'h10] !== 8'h12) begin
      $display("FAIL write_slave_reg: got %h required 12", s_mem[7'h10]); errors++;
    end
  endtask

  task automatic test_read();
    s_mem[7'h10] = 8'ha5; ref_mem[7'h10] = 8'ha5;
    do_cmd(1'b1, 7'h10, 8'h00, 1'b0, "read_0x10");
  endtask

  task automatic test_back_to_back();
    logic [6:0]  a;
    logic [7:0]  d, rd2;
    logic [15:0] got;
    int          nrsp, r1, r2, w, gap, hi_run, ready_bad;
    bit          acc_seen, seen_low, gap_done;
    a = 7'($urandom); d = 8'($urandom);
    ref_mem[a] = d;
    cmd_read = 1'b0; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    nrsp = 0; r1 = -1; r2 = -1; rd2 = 'x; gap = 0; hi_run = 0; ready_bad = 0;
    acc_seen = 0; seen_low = 0; gap_done = 0;
    for (int off = 0; off < 170; off++) begin
      @(negedge clk);
      if (off == 0) begin
        cmd_read = 1'b1; cmd_wdata = 8'($urandom);
      end
      if (acc_seen) cmd_valid = 1'b0;
      if (off > 0 && cmd_valid && cmd_ready === 1'b1) acc_seen = 1;
      if (ss === 1'b0 && cmd_ready !== 1'b0) ready_bad++;
      if (ss === 1'b0) begin
        if (seen_low && hi_run > 0 && !gap_done) begin
          gap = hi_run; gap_done = 1;
        end
        seen_low = 1; hi_run = 0;
      end else if (seen_low) begin
        hi_run++;
      end
      if (rsp_valid === 1'b1) begin
        nrsp++;
        if (nrsp == 1) r1 = off;
        if (nrsp == 2) begin
          r2 = off; rd2 = rsp_rdata;
        end
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (nrsp != 2 || r1 != LAT || r2 != 2 * LAT + 2) begin
      $display("FAIL b2b_rsp: pulses=%0d at %0d,%0d required 2 at %0d,%0d", nrsp, r1, r2, LAT, 2 * LAT + 2);
      errors++;
    end
    checks++;
    if (gap < GAP || ready_bad != 0) begin
      $display("FAIL b2b_gap: ss_gap=%0d ready_during_frame=%0d required >=%0d and 0", gap, ready_bad, GAP);
      errors++;
    end
    checks++;
    if (rd2 !== d) begin
      $display("FAIL b2b_rdata: got %h required %h", rd2, d); errors++;
    end
    checks++;
    if (frames_q.size() != 2) begin
      $display("FAIL b2b_frames: count %0d required 2", frames_q.size()); errors++;
      frames_q.delete();
    end else begin
      got = frames_q.pop_front();
      if (got !== {1'b0, a, d}) begin
        $display("FAIL b2b_frame_wr: got %h required %h", got, {1'b0, a, d}); errors++;
      end
      got = frames_q.pop_front();
      if (got !== {1'b1, a, 8'h00}) begin
        $display("FAIL b2b_frame_rd: got %h required %h", got, {1'b1, a, 8'h00}); errors++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_sck_div();
    int D[2], lowc[2], hic[2], rises[2], bad[2], rl[2], nrsp[2];
    logic pss[2], psck[2], rv[2];
    logic s, k;
    int w;
    D[0] = 1; D[1] = 3;
    for (int i = 0; i < 2; i++) begin
      lowc[i] = 0; hic[i] = 0; rises[i] = 0; bad[i] = 0; rl[i] = 0; nrsp[i] = 0;
      pss[i] = 1'b1; psck[i] = 1'b0; rv[i] = 1'b0;
    end
    w = 0;
    while (aux_ready !== 2'b11 && w < 300) begin
      @(negedge clk);
      w++;
    end
    aux_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    aux_valid = 1'b0;
    checks++;
    if (aux_busy !== 2'b11) begin
      $display("FAIL div_busy: got %b required 11", aux_busy); errors++;
    end
    for (int off = 0; off < 300; off++) begin
      for (int i = 0; i < 2; i++) begin
        s = aux_ss[i]; k = aux_sck[i];
        if (aux_rsp[i] === 1'b1) nrsp[i]++;
        if (s === 1'b0) begin
          lowc[i]++;
          if (k) hic[i]++;
          if (k && !psck[i]) rises[i]++;
          if (!pss[i]) begin
            if (k == rv[i]) rl[i]++;
            else begin
              if (rl[i] != D[i]) bad[i]++;
              rv[i] = k; rl[i] = 1;
            end
          end else begin
            rv[i] = k; rl[i] = 1;
          end
        end else if (!pss[i]) begin
          if (rl[i] != D[i]) bad[i]++;
        end
        pss[i] = s; psck[i] = k;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (lowc[i] != D[i] * (2 * FB + 1)) begin
        $display("FAIL div%0d_ss_low: got %0d required %0d", D[i], lowc[i], D[i] * (2 * FB + 1)); errors++;
      end
      checks++;
      if (rises[i] != FB || hic[i] != D[i] * FB) begin
        $display("FAIL div%0d_sck: rises=%0d high=%0d required %0d %0d", D[i], rises[i], hic[i], FB, D[i] * FB);
        errors++;
      end
      checks++;
      if (bad[i] != 0) begin
        $display("FAIL div%0d_halfperiod: %0d wrong-width phases required 0", D[i], bad[i]); errors++;
      end
      checks++;
      if (nrsp[i] != 1) begin
        $display("FAIL div%0d_rsp: pulses=%0d required 1", D[i], nrsp[i]); errors++;
      end
    end
    checks++;
    if (aux_rdata0 !== 8'h00 || aux_rdata1 !== 8'h00) begin
      $display("FAIL div_rdata: got %h %h required 00 00", aux_rdata0, aux_rdata1); errors++;
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] keep;
    int w, rises, nrsp;
    logic prev_sck;
    keep = ref_mem[7'h22];
    cmd_read = 1'b0; cmd_addr = 7'h22; cmd_wdata = ~keep; cmd_valid = 1'b1;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    rises = 0; prev_sck = 1'b0; nrsp = 0;
    for (int off = 0; off < 200 && rises < 5; off++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (sck === 1'b1 && prev_sck !== 1'b1) rises++;
      prev_sck = sck;
    end
    reset = 1'b0;
    #1;
    checks++;
    if (rises != 5 || ss !== 1'b1 || sck !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL abort_pins: rises=%0d ss=%b sck=%b busy=%b required 5 1 0 0", rises, ss, sck, busy);
      errors++;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int off = 0; off < 100; off++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) nrsp++;
    end
    checks++;
    if (nrsp != 0 || frames_q.size() != 0) begin
      $display("FAIL abort_rsp: pulses=%0d frames=%0d required 0 0", nrsp, frames_q.size()); errors++;
      frames_q.delete();
    end
    checks++;
    if (s_mem[7'h22] !== keep) begin
      $display("FAIL abort_slave_reg: got %h required %h", s_mem[7'h22], keep); errors++;
    end
    do_cmd(1'b1, 7'h22, 8'h00, 1'b0, "after_abort_read");
  endtask

  task automatic test_hold_inputs();
    for (int n = 0; n < 4; n++) begin
      do_cmd(1'($urandom), 7'($urandom_range(0, 7)), 8'($urandom), 1'b1, "toggle_while_busy");
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      do_cmd(1'($urandom), 7'($urandom_range(0, 7) + 64), 8'($urandom), 1'b0, "random_cmd");
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'($urandom);
      s_mem[i]   = ref_mem[i];
    end
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_sck_div();
    test_mid_reset();
    test_hold_inputs();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

endmodule
